imem_responder: RTL and testbench

- Instruction-memory responder on the fetch side of the core; it serves the core's fetch requests.
- Accepts a byte-addressed fetch request (PC) over a valid/ready channel and returns the 32-bit instruction word on a valid/ready response channel after a programmable latency.
- Holds a word-organised instruction array that a testbench/loader port preloads.
- Flags misaligned and out-of-range fetches.

---
 rtl/imem_responder.sv | 105 ++++++++++
 tb/tb_imem_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
module imem_responder #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned     LATENCY   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_inst,
  output logic            rsp_err,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_addr,
  input  logic [31:0]     load_data
);

  localparam int unsigned     IDX_W = $clog2(DEPTH);
  localparam logic [XLEN-1:0] SPAN  = XLEN'(DEPTH * 4);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [31:0]     inst_q;
  logic            err_q;
  logic [31:0]     mem [DEPTH];

  logic [XLEN-1:0] req_off;
  logic [XLEN-1:0] load_off;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] load_idx;
  logic            req_err;
  logic            load_ok;
  logic            accept;

  assign req_off  = req_addr - BASE_ADDR;
  assign req_idx  = req_off[IDX_W+1:2];
  assign req_err  = (req_addr[1:0] != 2'b00) || (req_off >= SPAN);

  assign load_off = load_addr - BASE_ADDR;
  assign load_idx = load_off[IDX_W+1:2];
  assign load_ok  = (load_addr[1:0] == 2'b00) && (load_off < SPAN);

  // req_ready is forced low during reset even though state already reads IDLE.
  always_comb begin
    req_ready = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:    req_ready = 1'b1;
        RESP:    req_ready = rsp_ready;
        default: req_ready = 1'b0;
      endcase
    end
  end

  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign rsp_inst  = inst_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (load_en && load_ok) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      inst_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      inst_q <= req_err ? '0 : mem[req_idx];
      err_q  <= req_err;
      cnt    <= 4'(LATENCY - 1);
      state  <= (LATENCY == 1) ? RESP : WAIT;
    end else begin
      case (state)
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        rr1, rv1, re1;
  logic [31:0] ri1;
  logic        rr3, rv3, re3;
  logic [31:0] ri3;
  logic        rr4, rv4, re4;
  logic [31:0] ri4;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  imem_responder #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) d1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr1), .req_addr(req_addr),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_inst(ri1), .rsp_err(re1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(3)) d3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr3), .req_addr(req_addr),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_inst(ri3), .rsp_err(re3),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(4)) d4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr4), .req_addr(req_addr),
    .rsp_valid(rv4), .rsp_ready(rsp_ready), .rsp_inst(ri4), .rsp_err(re4),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // single fetch on the LATENCY=1 instance, checked one cycle after accept
  task automatic fetch1(input string tag, input logic [31:0] a,
                        input logic [31:0] exp_inst, input logic exp_err);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b1;
    check({tag, "_ready"}, 32'(rr1), 32'h1);
    step();
    req_valid = 1'b0;
    check({tag, "_valid"}, 32'(rv1), 32'h1);
    check({tag, "_inst"}, ri1, exp_inst);
    check({tag, "_err"}, 32'(re1), 32'(exp_err));
    step();
    check({tag, "_done"}, 32'(rv1), 32'h0);
  endtask

  logic [31:0] stream [4];

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    stream[0] = 32'h11;
    stream[1] = 32'h22;
    stream[2] = 32'h33;
    stream[3] = 32'h44;

    step();
    step();
    check("rst_valid", 32'(rv1), 32'h0);
    check("rst_inst", ri1, 32'h0);
    check("rst_err", 32'(re1), 32'h0);
    check("rst_ready", 32'(rr1), 32'h0);
    rst_n = 1'b1;
    step();
    check("idle_ready", 32'(rr1), 32'h1);

    // 1: preload and single fetch
    load_word(32'h8000_0000, 32'h0010_0093);
    check("t1_pre_valid", 32'(rv1), 32'h0);
    fetch1("t1", 32'h8000_0000, 32'h0010_0093, 1'b0);

    // 2: streaming back-to-back
    for (int i = 0; i < 4; i++) load_word(32'h8000_0000 + 32'(i * 4), stream[i]);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'h8000_0000 + 32'(i * 4);
      check($sformatf("t2_ready%0d", i), 32'(rr1), 32'h1);
      step();
      if (i == 3) req_valid = 1'b0;
      check($sformatf("t2_valid%0d", i), 32'(rv1), 32'h1);
      check($sformatf("t2_inst%0d", i), ri1, stream[i]);
    end
    step();
    check("t2_end_valid", 32'(rv1), 32'h0);

    // 3: backpressure on the LATENCY=3 instance
    reset_pulse();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h8000_0004;
    check("t3_ready", 32'(rr3), 32'h1);
    step();
    req_valid = 1'b0;
    req_addr  = 32'h8000_000C;
    check("t3_wait1_valid", 32'(rv3), 32'h0);
    check("t3_wait1_ready", 32'(rr3), 32'h0);
    step();
    check("t3_wait2_valid", 32'(rv3), 32'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_hold_valid%0d", i), 32'(rv3), 32'h1);
      check($sformatf("t3_hold_inst%0d", i), ri3, 32'h22);
      check($sformatf("t3_hold_ready%0d", i), 32'(rr3), 32'h0);
      if (i < 4) step();
    end
    rsp_ready = 1'b1;
    #1;
    check("t3_hs_ready", 32'(rr3), 32'h1);
    step();
    check("t3_after_valid", 32'(rv3), 32'h0);
    check("t3_after_inst", ri3, 32'h22);

    // 4: faults and range boundaries
    reset_pulse();
    fetch1("t4_mis", 32'h8000_0002, 32'h0, 1'b1);
    fetch1("t4_high", 32'h8000_1000, 32'h0, 1'b1);
    fetch1("t4_low", 32'h7FFF_FFFC, 32'h0, 1'b1);
    load_word(32'h8000_0FFC, 32'hDEAD_BEEF);
    fetch1("t4_last", 32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0);
    load_word(32'h8000_1000, 32'hBAD0_0000);
    load_word(32'h8000_0001, 32'hBAD0_0001);
    fetch1("t4_noalias", 32'h8000_0000, 32'h11, 1'b0);

    // 5: load/read race on word 5
    load_word(32'h8000_0014, 32'hAAAA_AAAA);
    load_en   = 1'b1;
    load_addr = 32'h8000_0014;
    load_data = 32'hBBBB_BBBB;
    req_valid = 1'b1;
    req_addr  = 32'h8000_0014;
    rsp_ready = 1'b1;
    step();
    load_en   = 1'b0;
    req_valid = 1'b0;
    check("t5_race_inst", ri1, 32'hAAAA_AAAA);
    check("t5_race_valid", 32'(rv1), 32'h1);
    step();
    fetch1("t5_new", 32'h8000_0014, 32'hBBBB_BBBB, 1'b0);

    // 6: reset mid-flight on the LATENCY=4 instance
    reset_pulse();
    req_valid = 1'b1;
    req_addr  = 32'h8000_0004;
    rsp_ready = 1'b1;
    check("t6_ready", 32'(rr4), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(rv4), 32'h0);
    check("t6_rst_ready", 32'(rr4), 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("t6_rel_ready", 32'(rr4), 32'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("t6_quiet%0d", i), 32'(rv4), 32'h0);
    end
    req_valid = 1'b1;
    req_addr  = 32'h8000_0014;
    step();
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check($sformatf("t6_lat%0d", i), 32'(rv4), 32'h0);
      step();
    end
    check("t6_resp_valid", 32'(rv4), 32'h1);
    check("t6_resp_inst", ri4, 32'hBBBB_BBBB);
    check("t6_resp_err", 32'(re4), 32'h0);
    step();
    check("t6_end_valid", 32'(rv4), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
